// File: rtl/ifetch_unit_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
// Requests use a valid/ready handshake; responses come back in request order.
interface ifetch_unit_if #(
    parameter int unsigned ADDR_W = 16
) ();
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rsp_valid;
    logic [31:0]       imem_rdata;

    // Fetch-unit side
    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rdata
    );

    // Memory side
    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rdata
    );
endinterface

// File: rtl/ifetch_unit.sv
// SISC instruction fetch stage: prefetches words into a small queue, loads the
// instruction register on demand and discards in-flight fetches on redirect.
module ifetch_unit #(
    parameter int unsigned       ADDR_W   = 16,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic              pc_rst,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              ir_load,
    ifetch_unit_if.master     imem,
    output logic [31:0]       ir,
    output logic [3:0]        opcode,
    output logic [3:0]        mm,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              instr_valid,
    output logic              ir_stall,
    output logic              halted
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {StIdle, StRun, StFlush, StHalted} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    // Address tag of the next response that will be kept
    logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  outst_q, outst_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic [31:0]       ir_q, ir_d;
    logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
    logic              stall_q, stall_d;

    logic [31:0]       q_data [DEPTH];
    logic [ADDR_W-1:0] q_addr [DEPTH];

    logic              req_valid;
    logic              fire;
    logic              redirect;
    logic              rsp_drop;
    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  outst_net;

    // Issue only while running and a queue slot is reserved for every request in flight
    assign req_valid = (state_q == StRun) &&
                       ((CNT_W+1)'(count_q) + (CNT_W+1)'(outst_q) < (CNT_W+1)'(DEPTH));
    assign fire      = req_valid & imem.imem_req_ready;
    assign redirect  = pc_rst | br_taken;
    assign rsp_drop  = imem.imem_rsp_valid && (drop_q != '0);
    assign push      = imem.imem_rsp_valid && (drop_q == '0) && !redirect;
    assign pop       = ir_load && (count_q != '0) && !redirect;
    assign outst_net = outst_q - CNT_W'(imem.imem_rsp_valid);

    assign imem.imem_req_valid = req_valid;
    assign imem.imem_addr      = fetch_pc_q;

    assign ir          = ir_q;
    assign opcode      = ir_q[31:28];
    assign mm          = ir_q[27:24];
    assign ir_pc       = ir_pc_q;
    assign instr_valid = (count_q != '0);
    assign ir_stall    = stall_q;
    assign halted      = (state_q == StHalted);

    // Next-state logic: redirect overrides queue traffic and IR loading
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        outst_d    = outst_net + CNT_W'(fire);
        drop_d     = drop_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        stall_d    = 1'b0;

        if (fire) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(1);
        end

        if (redirect) begin
            fetch_pc_d = pc_rst ? RESET_PC : br_target;
            rsp_pc_d   = pc_rst ? RESET_PC : br_target;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            // Everything still in flight, including a request accepted now, is stale
            drop_d     = outst_d;
            if (pc_rst) begin
                ir_d    = '0;
                ir_pc_d = '0;
            end
            state_d = (outst_net != '0) ? StFlush : StRun;
        end else begin
            if (rsp_drop) begin
                drop_d = drop_q - CNT_W'(1);
            end
            if (push) begin
                tail_d   = tail_q + PTR_W'(1);
                rsp_pc_d = rsp_pc_q + ADDR_W'(1);
            end
            if (pop) begin
                ir_d    = q_data[head_q];
                ir_pc_d = q_addr[head_q];
                head_d  = head_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            stall_d = ir_load && (count_q == '0);

            case (state_q)
                StIdle:   state_d = StRun;
                StRun:    if (pop && (q_data[head_q][31:28] == 4'hF)) state_d = StHalted;
                StFlush:  if (drop_d == '0) state_d = StRun;
                StHalted: state_d = StHalted;
                default:  state_d = StIdle;
            endcase
        end
    end

    // Control and IR registers
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            stall_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            stall_q    <= stall_d;
        end
    end

    // Queue storage; occupancy is tracked by count_q, so contents need no reset
    always_ff @(posedge clk) begin
        if (push) begin
            q_data[tail_q] <= imem.imem_rdata;
            q_addr[tail_q] <= rsp_pc_q;
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Randomised bench for ifetch_unit against a queue-based behavioural model.
module tb_ifetch_unit;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DEPTH  = 4;

    logic        clk;
    logic        rst_f;
    logic        pc_rst;
    logic        br_taken;
    logic [15:0] br_target;
    logic        ir_load;
    logic [31:0] ir;
    logic [3:0]  opcode;
    logic [3:0]  mm;
    logic [15:0] ir_pc;
    logic        instr_valid;
    logic        ir_stall;
    logic        halted;

    ifetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

    ifetch_unit #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .RESET_PC (16'h0000)
    ) dut (
        .clk         (clk),
        .rst_f       (rst_f),
        .pc_rst      (pc_rst),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .ir_load     (ir_load),
        .imem        (bus),
        .ir          (ir),
        .opcode      (opcode),
        .mm          (mm),
        .ir_pc       (ir_pc),
        .instr_valid (instr_valid),
        .ir_stall    (ir_stall),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] d; logic [15:0] a; } ent_t;
    typedef struct packed { logic drop; logic [15:0] a; } fly_t;
    typedef struct packed { logic [15:0] a; int unsigned due; } mreq_t;

    int unsigned n_chk, n_fail, cyc, lat_lo, lat_hi;
    logic [31:0] mem_img [65536];
    mreq_t       mq[$];
    logic [15:0] issued[$];

    // Reference model: prefetch buffer, in-flight list with drop marks, mode flags
    logic [15:0] m_pc, m_irpc;
    logic [31:0] m_ir;
    logic        m_idle, m_halt, m_flush, m_stall;
    ent_t        m_buf[$];
    fly_t        m_fly[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] word_fn(input logic [15:0] a);
        logic [3:0] op;
        op = (a % 13 == 7) ? 4'hF : 4'(a % 15);
        return {op, a[7:4], 8'hA5, a};
    endfunction

    function automatic logic exp_valid();
        return !m_idle && !m_halt && !m_flush &&
               (m_buf.size() + m_fly.size() < int'(DEPTH));
    endfunction

    function automatic logic any_drop();
        for (int i = 0; i < m_fly.size(); i++) if (m_fly[i].drop) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_pc = '0; m_irpc = '0; m_ir = '0;
        m_idle = 1'b1; m_halt = 1'b0; m_flush = 1'b0; m_stall = 1'b0;
        m_buf.delete(); m_fly.delete(); mq.delete();
    endtask

    task automatic compare_all();
        check("req_valid", bus.imem_req_valid, exp_valid());
        check("imem_addr", bus.imem_addr, m_pc);
        check("ir", ir, m_ir);
        check("opcode", opcode, m_ir[31:28]);
        check("mm", mm, m_ir[27:24]);
        check("ir_pc", ir_pc, m_irpc);
        check("instr_valid", instr_valid, m_buf.size() != 0);
        check("ir_stall", ir_stall, m_stall);
        check("halted", halted, m_halt);
    endtask

    // One clock cycle: drive inputs and memory at the negedge, advance the model, check next negedge
    task automatic step(input logic rdy, input logic ld, input logic br, input logic prst,
                        input logic [15:0] tgt);
        logic v, fire, rsp, redir, pop;
        logic [31:0] rd;
        ent_t e;
        fly_t f;
        v = exp_valid();
        bus.imem_req_ready = rdy;
        ir_load   = ld;
        br_taken  = br;
        pc_rst    = prst;
        br_target = tgt;
        rsp = (mq.size() > 0) && (mq[0].due <= cyc);
        rd  = rsp ? mem_img[mq[0].a] : $urandom();
        bus.imem_rsp_valid = rsp;
        bus.imem_rdata     = rd;
        if (rsp) void'(mq.pop_front());
        if (bus.imem_req_valid && rdy) begin
            mq.push_back('{a: bus.imem_addr, due: cyc + $urandom_range(lat_hi, lat_lo)});
            issued.push_back(bus.imem_addr);
        end

        fire  = v && rdy;
        redir = br || prst;
        pop   = ld && (m_buf.size() > 0) && !redir;
        m_stall = ld && (m_buf.size() == 0) && !redir;
        f = '0;
        if (rsp) begin
            check("rsp_in_flight", m_fly.size() > 0, 1'b1);
            if (m_fly.size() > 0) f = m_fly.pop_front();
        end
        if (redir) begin
            m_flush = (m_fly.size() != 0);
            for (int i = 0; i < m_fly.size(); i++) m_fly[i].drop = 1'b1;
            if (fire) m_fly.push_back('{drop: 1'b1, a: m_pc});
            m_buf.delete();
            m_pc = prst ? 16'h0000 : tgt;
            if (prst) begin
                m_ir   = '0;
                m_irpc = '0;
            end
            m_halt = 1'b0;
            m_idle = 1'b0;
        end else begin
            if (pop) begin
                e = m_buf.pop_front();
                m_ir   = e.d;
                m_irpc = e.a;
                if (e.d[31:28] == 4'hF && !m_idle && !m_halt && !m_flush) m_halt = 1'b1;
            end
            if (rsp && !f.drop) m_buf.push_back('{d: rd, a: f.a});
            if (fire) begin
                m_fly.push_back('{drop: 1'b0, a: m_pc});
                m_pc = m_pc + 16'd1;
            end
            m_idle = 1'b0;
            if (m_flush && !any_drop()) m_flush = 1'b0;
        end
        cyc++;
        @(negedge clk);
        compare_all();
    endtask

    // Asynchronous reset applied between clock edges; outputs must clear at once
    task automatic apply_reset();
        #3;
        rst_f = 1'b0;
        pc_rst = 1'b0; br_taken = 1'b0; ir_load = 1'b0;
        bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0;
        #1;
        check("rst_req_valid", bus.imem_req_valid, 1'b0);
        check("rst_imem_addr", bus.imem_addr, 16'h0000);
        check("rst_ir", ir, 32'h0);
        check("rst_opcode", opcode, 4'h0);
        check("rst_ir_pc", ir_pc, 16'h0000);
        check("rst_instr_valid", instr_valid, 1'b0);
        check("rst_ir_stall", ir_stall, 1'b0);
        check("rst_halted", halted, 1'b0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_f = 1'b1;
    endtask

    logic [31:0] ir_hold;
    logic [15:0] addr_hold;
    int unsigned n_iss;

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0; lat_lo = 1; lat_hi = 1;
        for (int i = 0; i < 65536; i++) mem_img[i] = word_fn(16'(i));
        mem_img[0]       = 32'h8100_0005;
        mem_img[16'hFFFF] = 32'hF000_0000;
        rst_f = 1'b0; pc_rst = 1'b0; br_taken = 1'b0; br_target = '0; ir_load = 1'b0;
        bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rdata = '0;
        @(negedge clk);
        apply_reset();

        // Fill: four requests 0..3 then issue stops with the queue full
        issued.delete();
        repeat (8) step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        check("t1_issued_n", issued.size(), 4);
        for (int i = 0; i < issued.size() && i < 4; i++) check("t1_issued_addr", issued[i], 32'(i));
        check("t1_instr_valid", instr_valid, 1'b1);
        check("t1_issue_stopped", bus.imem_req_valid, 1'b0);

        // Pop head into IR; a freed slot lets issue resume at 4
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        check("t2_ir", ir, 32'h8100_0005);
        check("t2_opcode", opcode, 4'h8);
        check("t2_mm", mm, 4'h1);
        check("t2_ir_pc", ir_pc, 16'h0000);
        check("t2_resume_valid", bus.imem_req_valid, 1'b1);
        check("t2_resume_addr", bus.imem_addr, 16'h0004);

        // Redirect with slow responses still outstanding
        lat_lo = 3; lat_hi = 3;
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0040);
        repeat (12) step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        check("t3_first_ir_pc", ir_pc, 16'h0040);
        check("t3_first_ir", ir, mem_img[16'h0040]);

        // Redirect beats ir_load; ir_load on an empty queue stalls for one cycle
        ir_hold = m_ir;
        step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0100);
        check("t4_ir_kept_on_redirect", ir, ir_hold);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        check("t4_stall", ir_stall, 1'b1);
        check("t4_ir_kept_on_empty", ir, ir_hold);
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        check("t4_stall_one_cycle", ir_stall, 1'b0);

        // Address wrap, halt on opcode F, restart via pc_rst
        lat_lo = 1; lat_hi = 1;
        step(1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFF);
        issued.delete();
        repeat (8) step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        check("t5_issued_n_min", issued.size() >= 2, 1'b1);
        if (issued.size() >= 2) begin
            check("t5_addr_ffff", issued[0], 16'hFFFF);
            check("t5_addr_wrap", issued[1], 16'h0000);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        check("t5_halted", halted, 1'b1);
        n_iss = issued.size();
        repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        check("t5_no_issue_halted", issued.size(), n_iss);
        step(1'b1, 1'b0, 1'b0, 1'b1, 16'h1234);
        check("t5_restart_addr", bus.imem_addr, 16'h0000);
        check("t5_restart_ir", ir, 32'h0);
        check("t5_unhalted", halted, 1'b0);

        // Stalled request holds its address; reset mid-stall
        addr_hold = m_pc;
        repeat (5) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
            check("t6_addr_stable", bus.imem_addr, addr_hold);
        end
        apply_reset();

        // Random traffic
        lat_lo = 1; lat_hi = 4;
        repeat (3000) begin
            step($urandom_range(9, 0) < 7, $urandom_range(9, 0) < 4,
                 $urandom_range(99, 0) < 3, $urandom_range(99, 0) < 1,
                 ($urandom_range(9, 0) == 0) ? 16'hFFFF : 16'($urandom()));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
